// File: rtl/block_mem_arbiter_if.sv
// Bus bundle between the two cache refill ports, the arbiter and data_mem.
// The slave modport is the arbiter's view. The master modport is the view
// of the requesters and the memory that sit around the arbiter.
interface block_mem_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BLOCK_WIDTH   = 128
);
  // icache refill port
  logic                     ic_req;
  logic [ADDRESS_WIDTH-1:0] ic_addr;
  logic [BLOCK_WIDTH-1:0]   ic_rdata;
  logic                     ic_ack;
  // dcache refill / writeback port
  logic                     dc_req;
  logic                     dc_we;
  logic [ADDRESS_WIDTH-1:0] dc_addr;
  logic [BLOCK_WIDTH-1:0]   dc_wdata;
  logic [BLOCK_WIDTH-1:0]   dc_rdata;
  logic                     dc_ack;
  // data_mem side
  logic                     mem_wr_en;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [BLOCK_WIDTH-1:0]   mem_wdata;
  logic [BLOCK_WIDTH-1:0]   mem_rdata;
  // status
  logic                     busy;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata,
    output ic_rdata, ic_ack, dc_rdata, dc_ack, mem_wr_en, mem_addr, mem_wdata, busy
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata,
    input  ic_rdata, ic_ack, dc_rdata, dc_ack, mem_wr_en, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/block_mem_arbiter.sv
// Round-robin arbiter that shares the single block data memory between the
// icache refill port and the dcache refill/writeback port. The winning
// request is latched and held on the memory bus for MEM_LATENCY cycles. A
// read block is captured into the winner's rdata register on the last of
// those cycles. The winner then gets a one-cycle ack.
module block_mem_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BLOCK_WIDTH   = 128,
  parameter int MEM_LATENCY   = 4
) (
  input  logic               clk,
  input  logic               rst,
  block_mem_arbiter_if.slave bus
);

  // The counter must hold MEM_LATENCY-1. Its width never drops below one bit.
  localparam int               CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_e;

  typedef enum logic {
    OWN_IC,
    OWN_DC
  } owner_e;

  state_e                   state;
  state_e                   state_nxt;
  owner_e                   owner;
  owner_e                   last_grant;
  logic [CNT_W-1:0]         cnt;
  logic [ADDRESS_WIDTH-1:0] lat_addr;
  logic [BLOCK_WIDTH-1:0]   lat_wdata;
  logic                     lat_we;
  logic [BLOCK_WIDTH-1:0]   ic_rdata_q;
  logic [BLOCK_WIDTH-1:0]   dc_rdata_q;
  logic                     grant_any;
  logic                     grant_dc;
  logic                     final_cycle;

  // Request arbitration: on a tie, grant the port that did not win last time.
  always_comb begin
    // NOTE: every variable written here gets a value on every path, so no latch is inferred.
    grant_any = bus.ic_req | bus.dc_req;
    grant_dc  = bus.dc_req & (~bus.ic_req | (last_grant == OWN_IC));
  end

  assign final_cycle = (state == ST_ACCESS) && (cnt == '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses <= so that every flop samples values from before the edge.
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: IDLE -> ACCESS -> DONE -> IDLE. No arbitration happens in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (grant_any) state_nxt = ST_ACCESS;
      ST_ACCESS: if (cnt == '0) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: latch the winner at grant, count the access, capture read blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= OWN_IC;
      last_grant <= OWN_IC;
      cnt        <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_we     <= 1'b0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
    end else begin
      if ((state == ST_IDLE) && grant_any) begin
        owner      <= grant_dc ? OWN_DC : OWN_IC;
        last_grant <= grant_dc ? OWN_DC : OWN_IC;
        lat_addr   <= grant_dc ? bus.dc_addr : bus.ic_addr;
        lat_we     <= grant_dc & bus.dc_we;
        cnt        <= CNT_LOAD;
        // The icache never writes, so the write latch keeps the last dcache block.
        if (grant_dc) lat_wdata <= bus.dc_wdata;
      end else if ((state == ST_ACCESS) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end

      // The memory read port is combinational. Sample it on the final access edge.
      if (final_cycle && !lat_we) begin
        if (owner == OWN_IC) ic_rdata_q <= bus.mem_rdata;
        else                 dc_rdata_q <= bus.mem_rdata;
      end
    end
  end

  // Outputs: write strobe on the final access cycle only, ack to the owner in DONE.
  always_comb begin
    bus.mem_wr_en = final_cycle & lat_we;
    bus.ic_ack    = (state == ST_DONE) && (owner == OWN_IC);
    bus.dc_ack    = (state == ST_DONE) && (owner == OWN_DC);
    bus.busy      = (state != ST_IDLE);
  end

  assign bus.mem_addr  = lat_addr;
  assign bus.mem_wdata = lat_wdata;
  assign bus.ic_rdata  = ic_rdata_q;
  assign bus.dc_rdata  = dc_rdata_q;

endmodule

// File: tb/tb_block_mem_arbiter.sv
// Bench for block_mem_arbiter. Requester tasks push the response each
// transaction should produce into per-port queues. A monitor pops those
// entries on every ack and on every memory write strobe. Expected read data
// comes from a shadow copy of memory. Expected latency comes from the
// arbitration rules: L+1 when the port is uncontended, and at most 2L+3
// when it has to wait.
module tb_block_mem_arbiter;

  localparam int L  = 4;
  localparam int AW = 32;
  localparam int BW = 128;

  typedef struct {
    bit            is_wr;
    logic [BW-1:0] data;     // read block, or the rdata value that must be held across a write
    int            t_issue;
    int            exp_lat;  // -1: only the contention bounds apply
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t ic_q[$];
  exp_t dc_q[$];
  wr_t  wr_q[$];

  logic [BW-1:0] mem     [0:127];
  logic [BW-1:0] ref_mem [0:127];
  logic [BW-1:0] dc_last;
  bit            gap_chk = 1'b0;

  block_mem_arbiter_if #(.ADDRESS_WIDTH(AW), .BLOCK_WIDTH(BW)) bus  ();
  block_mem_arbiter_if #(.ADDRESS_WIDTH(AW), .BLOCK_WIDTH(BW)) bus1 ();

  block_mem_arbiter #(.ADDRESS_WIDTH(AW), .BLOCK_WIDTH(BW), .MEM_LATENCY(L)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  block_mem_arbiter #(.ADDRESS_WIDTH(AW), .BLOCK_WIDTH(BW), .MEM_LATENCY(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [BW-1:0] init_word(input int i);
    if (i == 16) return {16{8'hA5}};
    return {32'hC0DE_0000 + 32'(i), 32'h1234_5678 ^ 32'(i), ~32'(i), 32'(i) * 32'h0101_0101};
  endfunction

  // data_mem model: combinational read port, write committed at the clock edge.
  assign bus.mem_rdata  = mem[bus.mem_addr[10:4]];
  assign bus1.mem_rdata = {4{bus1.mem_addr}};

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (bus.mem_wr_en) mem[bus.mem_addr[10:4]] = bus.mem_wdata;
    end
  end

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- monitor ----------------
  logic [BW-1:0] ic_hold, dc_hold;
  bit            prev_wr, prev_ic_ack, prev_dc_ack;
  int            last_ack_cyc;
  exp_t          m_ic, m_dc;
  wr_t           m_wr;
  int            m_lat;

  function automatic int clamp_lat(input int lat);
    if (lat < L + 1)     return L + 1;
    if (lat > 2 * L + 3) return 2 * L + 3;
    return lat;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      ic_hold      = '0;
      dc_hold      = '0;
      prev_wr      = 1'b0;
      prev_ic_ack  = 1'b0;
      prev_dc_ack  = 1'b0;
      last_ack_cyc = -1;
    end else begin
      if (bus.mem_wr_en) begin
        check("wr_en_has_pending_write", wr_q.size() != 0, 1'b1);
        if (wr_q.size() != 0) begin
          m_wr = wr_q.pop_front();
          check("wr_addr", bus.mem_addr, m_wr.addr);
          check("wr_data", bus.mem_wdata, m_wr.data);
        end
      end
      if (bus.ic_ack) begin
        check("ic_ack_single_cycle", prev_ic_ack, 1'b0);
        check("acks_exclusive", bus.dc_ack, 1'b0);
        check("busy_in_ack", bus.busy, 1'b1);
        check("ic_ack_has_pending", ic_q.size() != 0, 1'b1);
        if (ic_q.size() != 0) begin
          m_ic  = ic_q.pop_front();
          m_lat = cyc - m_ic.t_issue;
          if (m_ic.exp_lat >= 0) check("ic_latency", m_lat, m_ic.exp_lat);
          else                   check("ic_latency_bounds", m_lat, clamp_lat(m_lat));
          check("ic_rdata", bus.ic_rdata, m_ic.data);
          ic_hold = m_ic.data;
        end
        check("dc_rdata_held", bus.dc_rdata, dc_hold);
      end
      if (bus.dc_ack) begin
        check("dc_ack_single_cycle", prev_dc_ack, 1'b0);
        check("dc_ack_has_pending", dc_q.size() != 0, 1'b1);
        if (dc_q.size() != 0) begin
          m_dc  = dc_q.pop_front();
          m_lat = cyc - m_dc.t_issue;
          if (m_dc.exp_lat >= 0) check("dc_latency", m_lat, m_dc.exp_lat);
          else                   check("dc_latency_bounds", m_lat, clamp_lat(m_lat));
          if (m_dc.is_wr) check("wr_en_before_dc_ack", prev_wr, 1'b1);
          check("dc_rdata", bus.dc_rdata, m_dc.data);
          if (!m_dc.is_wr) dc_hold = m_dc.data;
        end
        check("ic_rdata_held", bus.ic_rdata, ic_hold);
      end
      if (gap_chk && (bus.ic_ack || bus.dc_ack)) begin
        if (last_ack_cyc >= 0) check("ack_period", cyc - last_ack_cyc, L + 2);
        last_ack_cyc = cyc;
      end
      prev_wr     = bus.mem_wr_en;
      prev_ic_ack = bus.ic_ack;
      prev_dc_ack = bus.dc_ack;
    end
  end

  // ---------------- requesters (called at posedge + 1) ----------------
  task automatic ic_txn(input logic [AW-1:0] addr, input int exp_lat);
    exp_t e;
    int   budget;
    e.is_wr   = 1'b0;
    e.data    = ref_mem[addr[10:4]];
    e.t_issue = cyc;
    e.exp_lat = exp_lat;
    ic_q.push_back(e);
    bus.ic_addr = addr;
    bus.ic_req  = 1'b1;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!bus.ic_ack && budget < 40);
    if (!bus.ic_ack) check("ic_ack_timeout", bus.ic_ack, 1'b1);
    @(posedge clk); #1;
    bus.ic_req = 1'b0;
  endtask

  task automatic dc_txn(input logic we, input logic [AW-1:0] addr, input logic [BW-1:0] wdata,
                        input int exp_lat);
    exp_t e;
    wr_t  w;
    int   budget;
    e.is_wr   = we;
    e.t_issue = cyc;
    e.exp_lat = exp_lat;
    if (we) begin
      e.data = dc_last;
      ref_mem[addr[10:4]] = wdata;
      w.addr = addr;
      w.data = wdata;
      wr_q.push_back(w);
    end else begin
      e.data  = ref_mem[addr[10:4]];
      dc_last = e.data;
    end
    dc_q.push_back(e);
    bus.dc_addr  = addr;
    bus.dc_we    = we;
    bus.dc_wdata = wdata;
    bus.dc_req   = 1'b1;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!bus.dc_ack && budget < 40);
    if (!bus.dc_ack) check("dc_ack_timeout", bus.dc_ack, 1'b1);
    @(posedge clk); #1;
    bus.dc_req = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [BW-1:0] wblk;
    for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
    dc_last = '0;
    {bus.ic_req, bus.dc_req, bus.dc_we} = '0;
    bus.ic_addr = '0; bus.dc_addr = '0; bus.dc_wdata = '0;
    {bus1.ic_req, bus1.dc_req, bus1.dc_we} = '0;
    bus1.ic_addr = '0; bus1.dc_addr = '0; bus1.dc_wdata = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("rst_ic_ack",    bus.ic_ack,    1'b0);
    check("rst_dc_ack",    bus.dc_ack,    1'b0);
    check("rst_ic_rdata",  bus.ic_rdata,  '0);
    check("rst_dc_rdata",  bus.dc_rdata,  '0);
    check("rst_mem_wr_en", bus.mem_wr_en, 1'b0);
    check("rst_mem_addr",  bus.mem_addr,  '0);
    check("rst_mem_wdata", bus.mem_wdata, '0);
    check("rst_busy",      bus.busy,      1'b0);
    rst = 1'b0;

    // Both ports request in the same cycle after reset, then keep re-requesting.
    // The first tie goes to DC. After that the grants alternate, one every L+2 cycles.
    @(posedge clk); #1;
    gap_chk = 1'b1;
    fork
      for (int i = 0; i < 4; i++) dc_txn(1'b0, AW'((40 + i) << 4), '0, (i == 0) ? L + 1 : 2 * L + 3);
      for (int i = 0; i < 4; i++) ic_txn(AW'(i << 4), 2 * L + 3);
    join
    gap_chk = 1'b0;

    // Lone icache read of the preloaded 0x100. busy rises one cycle after the request.
    fork
      ic_txn(32'h100, L + 1);
      begin
        @(negedge clk); check("busy_in_request_cycle", bus.busy, 1'b0);
        @(negedge clk); check("busy_after_grant",      bus.busy, 1'b1);
      end
    join

    // dcache write of 0x200, then read it back.
    wblk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    dc_txn(1'b1, 32'h200, wblk, L + 1);
    dc_txn(1'b0, 32'h200, '0, L + 1);
    check("dc_readback_0x200", bus.dc_rdata, wblk);

    // Randomized traffic. IC reads blocks 0..31, DC reads and writes blocks 32..127.
    fork
      for (int i = 0; i < 25; i++) begin
        ic_txn(AW'($urandom_range(0, 31) << 4), -1);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      for (int i = 0; i < 25; i++) begin
        dc_txn(1'($urandom_range(0, 1)), AW'($urandom_range(32, 127) << 4),
               {$urandom, $urandom, $urandom, $urandom}, -1);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
    join

    // Reset asserted in the second ACCESS cycle of a dcache write.
    @(posedge clk); #1;
    bus.dc_addr  = 32'h640;
    bus.dc_we    = 1'b1;
    bus.dc_wdata = {4{32'hDEAD_BEEF}};
    bus.dc_req   = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_busy",      bus.busy,      1'b0);
    check("midrst_mem_wr_en", bus.mem_wr_en, 1'b0);
    check("midrst_mem_addr",  bus.mem_addr,  '0);
    check("midrst_mem_wdata", bus.mem_wdata, '0);
    check("midrst_dc_ack",    bus.dc_ack,    1'b0);
    check("midrst_dc_rdata",  bus.dc_rdata,  '0);
    check("midrst_ic_rdata",  bus.ic_rdata,  '0);
    bus.dc_req = 1'b0;
    bus.dc_we  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    dc_last = '0;
    repeat (8) @(posedge clk); #1;
    check("midrst_mem_unchanged", mem[100], ref_mem[100]);
    check("midrst_idle_after",    bus.busy, 1'b0);

    // MEM_LATENCY = 1 instance: one ACCESS cycle, ack two cycles after the request.
    bus1.ic_addr = 32'h340;
    bus1.ic_req  = 1'b1;
    @(negedge clk);
    check("l1_busy_req_cycle", bus1.busy, 1'b0);
    @(negedge clk);
    check("l1_mem_addr",  bus1.mem_addr, 32'h340);
    check("l1_busy",      bus1.busy,     1'b1);
    check("l1_ic_no_ack", bus1.ic_ack,   1'b0);
    @(negedge clk);
    check("l1_ic_ack",   bus1.ic_ack,   1'b1);
    check("l1_ic_rdata", bus1.ic_rdata, {4{32'h340}});
    @(posedge clk); #1;
    bus1.ic_req   = 1'b0;
    bus1.dc_addr  = 32'h50;
    bus1.dc_we    = 1'b1;
    bus1.dc_wdata = {4{32'h0BAD_F00D}};
    bus1.dc_req   = 1'b1;
    @(negedge clk);
    check("l1_wr_en_req_cycle", bus1.mem_wr_en, 1'b0);
    @(negedge clk);
    check("l1_wr_en",    bus1.mem_wr_en, 1'b1);
    check("l1_wr_addr",  bus1.mem_addr,  32'h50);
    check("l1_wr_wdata", bus1.mem_wdata, {4{32'h0BAD_F00D}});
    @(negedge clk);
    check("l1_wr_en_done", bus1.mem_wr_en, 1'b0);
    check("l1_dc_ack",     bus1.dc_ack,    1'b1);
    check("l1_dc_rdata",   bus1.dc_rdata,  '0);
    check("l1_ic_rdata_held", bus1.ic_rdata, {4{32'h340}});
    @(posedge clk); #1;
    bus1.dc_req = 1'b0;
    bus1.dc_we  = 1'b0;
    repeat (3) @(posedge clk); #1;

    check("ic_q_drained", ic_q.size(), 0);
    check("dc_q_drained", dc_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
